sienna_pipeline_sequencer: RTL
==============================

Name: sienna_pipeline_sequencer

Overview:
Top-level sequencer for the four-stage SIENNA datapath: systolic array (stage 0), GPNAE (stage 1), maxpool (stage 2) and dropout (stage 3). It takes one start request and walks the enabled stages in fixed order. For each stage it issues a one-cycle start pulse and waits for that stage's done pulse. It aborts with an error code if a stage exceeds its watchdog budget. It sits between the top-level control interface and the stage start/done handshakes inside sienna_top.

Parameters:
NUM_STAGES, 4, number of sequenced stages (fixed order 0..NUM_STAGES-1)
TIMEOUT_W, 24, width of the per-stage watchdog counter
TIMEOUT_CYCLES, 24'd1_000_000, maximum cycles from a stage's start pulse to its done pulse
CNT_W, 32, width of the total-run cycle counter

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  start request; sampled only in IDLE
abort_i  in  1  software abort; honoured in any non-IDLE state
stage_en_i  in  NUM_STAGES  stage enable mask, latched on an accepted start
stage_done_i  in  NUM_STAGES  per-stage done pulse
stage_start_o  out  NUM_STAGES  one-hot, single-cycle stage start pulse
busy_o  out  1  high from accepted start until return to IDLE
done_o  out  1  single-cycle pulse on successful completion
error_o  out  1  sticky error flag; cleared by the next accepted start
err_code_o  out  2  01=timeout, 10=abort, 11=spurious done, 00=none
err_stage_o  out  2  stage index active when the error occurred
cur_stage_o  out  2  stage index currently launched/awaited
run_cycles_o  out  CNT_W  cycles from accepted start to done/error; holds afterwards

Behaviour:
- Reset (async, rst_i=1): state=IDLE. All outputs 0. Latched mask=0. Counters=0.
- IDLE: start_i=1 -> latch stage_en_i, clear error_o/err_code_o/err_stage_o/run_cycles_o, go to SELECT.
  - If the latched mask is 0 -> go directly to FINISH (done_o pulses 2 cycles after start).
- SELECT: find the lowest enabled index >= the current pointer and go to LAUNCH. If none remains -> FINISH.
- LAUNCH: stage_start_o[idx]=1 for exactly this one cycle, watchdog cleared, cur_stage_o=idx -> WAIT.
- WAIT: watchdog increments each cycle.
  - stage_done_i[idx]=1 -> pointer=idx+1, go to SELECT. Latency from done to the next start pulse is 2 cycles.
  - watchdog reaches TIMEOUT_CYCLES -> ERROR with code 01.
  - done on any other bit, in any non-IDLE state -> ERROR with code 11. This takes priority over the same-cycle valid done.
- FINISH: done_o=1 for one cycle -> IDLE.
- ERROR: error_o=1, code/stage latched, then IDLE in the next cycle. error_o stays set until the next accepted start.
- abort_i in any non-IDLE state -> ERROR with code 10. Abort has priority over done and timeout in the same cycle.
- busy_o=1 in every state except IDLE.
- run_cycles_o increments each cycle while busy and saturates at all-ones.
- start_i while busy is ignored, with no queueing.
- stage_done_i in IDLE is ignored.
- Done in the same cycle as LAUNCH is ignored; the stage must respond at least one cycle after its start.

Optional Feature:
- Macro: SIENNA_SEQ_PERF_EN.
- Defined: adds output stage_cycles_o [NUM_STAGES*CNT_W], the per-stage start-to-done latency.
  - Each field is written when its stage completes and cleared on an accepted start.
  - Disabled stages read 0.
- Undefined: the port and its counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sienna_seq_pkg contains:
  - seq_state_e enum: IDLE, SELECT, LAUNCH, WAIT, FINISH, ERROR
  - err_code_e enum: NONE, TIMEOUT, ABORT, SPURIOUS
  - stage_idx_t typedef
  - stage index localparams: STG_SYSTOLIC=0, STG_GPNAE=1, STG_MAXPOOL=2, STG_DROPOUT=3
- Sub-module: sienna_seq_watchdog, holding the clearable counter and the terminal-count compare (TIMEOUT_W, TIMEOUT_CYCLES).

Test Plan:
- Full run: mask=4'b1111, each stage returns done 5 cycles after its start -> starts fire in order 0,1,2,3; done_o pulses once; error_o=0; run_cycles_o equals the cycle count from start to done.
- Sparse mask: mask=4'b1010 -> only stage_start_o[1] and [3] pulse. Mask=0 -> done_o exactly 2 cycles after start, no start pulses.
- Timeout: TIMEOUT_CYCLES=16, stage 2 never answers -> error_o=1, err_code_o=01, err_stage_o=2 at cycle 16 after the stage-2 start. No done_o. The next start clears the error.
- Abort/priority: abort_i asserted in the same cycle as stage_done_i[1] -> err_code_o=10, err_stage_o=1. Stage 2 never starts.
- Spurious done: stage_done_i[3] while waiting on stage 0 -> err_code_o=11, err_stage_o=0. A second start_i while busy is ignored.
- Reset mid-run: rst_i asserted during WAIT of stage 1 -> all outputs 0 immediately (async). After release, a start with mask=4'b0001 completes normally.

Source files
------------

// File: rtl/sienna_seq_pkg.sv
// sienna_seq_pkg: shared types for the SIENNA four-stage sequencer.
// Optional per-stage latency outputs are enabled by SIENNA_SEQ_PERF_EN.
package sienna_seq_pkg;

  localparam int SEQ_STAGES = 4;
  localparam int STG_W      = 2;

  typedef logic [STG_W-1:0] stage_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    LAUNCH,
    WAIT,
    FINISH,
    ERROR
  } seq_state_e;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    TIMEOUT  = 2'b01,
    ABORT    = 2'b10,
    SPURIOUS = 2'b11
  } err_code_e;

  localparam stage_idx_t STG_SYSTOLIC = 2'd0;
  localparam stage_idx_t STG_GPNAE    = 2'd1;
  localparam stage_idx_t STG_MAXPOOL  = 2'd2;
  localparam stage_idx_t STG_DROPOUT  = 2'd3;

  function automatic logic [SEQ_STAGES-1:0] stage_onehot(
    input stage_idx_t idx
  );
    logic [SEQ_STAGES-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sienna_seq_watchdog.sv
// sienna_seq_watchdog: clearable per-stage cycle counter that flags
// expiry on the cycle a stage has been waited on TIMEOUT_CYCLES times.
module sienna_seq_watchdog
  import sienna_seq_pkg::*;
#(
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds completed wait cycles, so this fires on the last allowed one
  assign expired_o = en_i &&
    (cnt_q >= (TIMEOUT_CYCLES - TIMEOUT_W'(1)));

endmodule

// File: rtl/sienna_pipeline_sequencer.sv
// sienna_pipeline_sequencer: walks the enabled SIENNA stages in order.
// Define SIENNA_SEQ_PERF_EN to add stage_cycles_o latency reporting.
module sienna_pipeline_sequencer
  import sienna_seq_pkg::*;
#(
  parameter int                   NUM_STAGES     = SEQ_STAGES,
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd1_000_000,
  parameter int                   CNT_W          = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [NUM_STAGES-1:0]   stage_en_i,
  input  logic [NUM_STAGES-1:0]   stage_done_i,
  output logic [NUM_STAGES-1:0]   stage_start_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [1:0]              err_code_o,
  output logic [1:0]              err_stage_o,
  output logic [1:0]              cur_stage_o,
`ifdef SIENNA_SEQ_PERF_EN
  output logic [NUM_STAGES*CNT_W-1:0] stage_cycles_o,
`endif
  output logic [CNT_W-1:0]        run_cycles_o
);

  localparam int PTR_W = $clog2(NUM_STAGES + 1);

  seq_state_e            state_q, state_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  stage_idx_t            idx_q, idx_d;
  logic                  err_q, err_d;
  err_code_e             code_q, code_d;
  stage_idx_t            estg_q, estg_d;
  logic [CNT_W-1:0]      run_q, run_d;

  logic                  wd_clr;
  logic                  wd_en;
  logic                  wd_exp;
  logic                  found;
  stage_idx_t            nxt;
  logic [NUM_STAGES-1:0] exp_mask;
  logic                  active;
  logic                  spurious;
  logic                  hit;
  logic                  stage_ok;

  sienna_seq_watchdog #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wd (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_exp)
  );

  // lowest enabled stage at or above the resume pointer
  always_comb begin
    found = 1'b0;
    nxt   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (mask_q[i] && (PTR_W'(i) >= ptr_q)) begin
        found = 1'b1;
        nxt   = stage_idx_t'(i);
      end
    end
  end

  always_comb begin
    exp_mask = '0;
    if ((state_q == LAUNCH) || (state_q == WAIT)) begin
      exp_mask = NUM_STAGES'(stage_onehot(idx_q));
    end
  end

  assign active = (state_q == SELECT) || (state_q == LAUNCH) ||
                  (state_q == WAIT)   || (state_q == FINISH);
  assign spurious = active && |(stage_done_i & ~exp_mask);
  assign hit = (state_q == WAIT) && |(stage_done_i & exp_mask);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    err_d    = err_q;
    code_d   = code_q;
    estg_d   = estg_q;
    run_d    = run_q;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    stage_ok = 1'b0;

    if ((state_q != IDLE) && (run_q != '1)) begin
      run_d = run_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mask_d  = stage_en_i;
          ptr_d   = '0;
          err_d   = 1'b0;
          code_d  = NONE;
          estg_d  = '0;
          run_d   = '0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (found) begin
          idx_d   = nxt;
          state_d = LAUNCH;
        end else begin
          state_d = FINISH;
        end
      end
      LAUNCH: begin
        wd_clr  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        wd_en = 1'b1;
        if (hit) begin
          stage_ok = 1'b1;
          ptr_d    = PTR_W'(idx_q) + PTR_W'(1);
          state_d  = SELECT;
        end else if (wd_exp) begin
          err_d   = 1'b1;
          code_d  = TIMEOUT;
          estg_d  = idx_q;
          state_d = ERROR;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      ERROR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // abort outranks a stray done, which outranks done/timeout
    if (active && (abort_i || spurious)) begin
      stage_ok = 1'b0;
      ptr_d    = ptr_q;
      err_d    = 1'b1;
      code_d   = abort_i ? ABORT : SPURIOUS;
      estg_d   = idx_q;
      state_d  = ERROR;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= NONE;
      estg_q  <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      code_q  <= code_d;
      estg_q  <= estg_d;
      run_q   <= run_d;
    end
  end

`ifdef SIENNA_SEQ_PERF_EN
  logic [CNT_W-1:0]                 lat_q, lat_d;
  logic [NUM_STAGES-1:0][CNT_W-1:0] perf_q, perf_d;

  always_comb begin
    lat_d  = lat_q;
    perf_d = perf_q;
    if (state_q == LAUNCH) begin
      lat_d = '0;
    end else if ((state_q == WAIT) && (lat_q != '1)) begin
      lat_d = lat_q + CNT_W'(1);
    end
    if ((state_q == IDLE) && start_i) begin
      perf_d = '0;
    end else if (stage_ok) begin
      perf_d[idx_q] = lat_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_q  <= '0;
      perf_q <= '0;
    end else begin
      lat_q  <= lat_d;
      perf_q <= perf_d;
    end
  end

  assign stage_cycles_o = perf_q;
`endif

  assign stage_start_o = (state_q == LAUNCH) ?
    NUM_STAGES'(stage_onehot(idx_q)) : '0;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == FINISH);
  assign error_o      = err_q;
  assign err_code_o   = code_q;
  assign err_stage_o  = estg_q;
  assign cur_stage_o  = idx_q;
  assign run_cycles_o = run_q;

endmodule
